bubble_multicycle_ctrl: RTL and testbench
=========================================

Name: bubble_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the BUBBLE datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states, and drives the datapath select lines: register-destination select, ALU-B select, writeback select and PC select. It also issues memory requests with a ready handshake and counts retired instructions. It sits between the instruction register and the datapath mux/ALU/memory blocks.

Parameters:
CNT_W, 16, width of retired-instruction counter
MAX_WAIT, 15, max cycles to wait for mem_ready before flagging a timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  enables leaving IDLE
opcode  in  6  instr[31:26], sampled only in DECODE
funct  in  6  instr[5:0], sampled only in DECODE
zero  in  1  ALU zero flag, valid in EXECUTE
mem_ready  in  1  memory completes current request this cycle
RegDst  out  1  0: rt (20:16), 1: rd (15:11)
ALUSrc  out  1  0: ReadData2, 1: sign-extended immediate
MemtoReg  out  1  0: ALU result, 1: memory read data
PCSrc  out  1  0: PC+4, 1: branch target
PCWrite  out  1  PC register load enable
IRWrite  out  1  instruction register load enable
RegWrite  out  1  register-file write enable
mem_req  out  1  memory request valid
mem_we  out  1  1: store, 0: load/fetch (meaningful only when mem_req=1)
ALUOp  out  2  00 add, 01 sub, 10 R-type funct decode
illegal  out  1  sticky flag: unsupported opcode seen
timeout  out  1  sticky flag: MAX_WAIT exceeded
inst_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Encoded as 3 bits. Outputs are a Moore decode of state plus the latched opcode class. PCSrc/PCWrite in EXEC also depend on zero.
- Reset (async, active-high): state=IDLE, opcode class=NOP, inst_count=0, illegal=0, timeout=0, wait counter=0. Every control output is 0 while in IDLE.
- IDLE: advance to FETCH when run=1; otherwise stay.
- FETCH: mem_req=1, mem_we=0.
  - On mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE.
  - Otherwise hold; wait counter increments.
- DECODE: latch class from opcode. R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000; anything else is ILL. No control outputs are asserted.
  - Next state is EXEC.
  - For ILL: set illegal=1 and go to FETCH if run=1, else IDLE. ILL does not count as retired.
- EXEC, per class:
  - R: ALUSrc=0, ALUOp=10.
  - LW/SW/ADDI: ALUSrc=1, ALUOp=00.
  - BEQ: ALUSrc=0, ALUOp=01, PCSrc=zero, PCWrite=zero. BEQ retires here.
- Next state after EXEC: LW/SW go to MEM, R/ADDI go to WB, BEQ goes to FETCH/IDLE.
- MEM: mem_req=1, mem_we=1 for SW, 0 for LW.
  - Hold until mem_ready=1.
  - Then SW retires and goes to FETCH/IDLE; LW goes to WB.
- WB: RegWrite=1 for one cycle.
  - RegDst=1 for R, 0 for LW/ADDI.
  - MemtoReg=1 for LW, 0 otherwise.
  - Retires, then goes to FETCH/IDLE.
- Retirement: inst_count increments by 1 in the retiring cycle and wraps from 2^CNT_W-1 to 0. "FETCH/IDLE" means FETCH if run=1 in that cycle, else IDLE. run=0 never aborts an in-flight instruction.
- Wait counter: clears on entering FETCH or MEM and on mem_ready. If it reaches MAX_WAIT with mem_ready still 0:
  - timeout=1, mem_req drops, state goes to IDLE.
  - Nothing retires and the PC is not written.
- illegal and timeout clear only on reset.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-instruction forces IDLE immediately. No partial RegWrite or PCWrite pulse may follow.

Decomposition:
- Shared package bubble_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI)
  - state encoding constants
  - ALUOp encodings
  - class encoding.
- One sub-module: bubble_mem_wait_timer, holding the wait counter and MAX_WAIT compare.

Test Plan:
- add (opcode 000000), mem_ready=1 each request -> FETCH,DECODE,EXEC,WB = 4 cycles. RegDst=1, ALUOp=10, RegWrite=1 in WB only, inst_count 0->1.
- lw (100011) with mem_ready delayed 3 cycles in FETCH and MEM -> 5 states plus 6 stall cycles. ALUSrc=1 in EXEC, mem_we=0, MemtoReg=1 and RegDst=0 in WB.
- beq (000100) with zero=1, then zero=0 -> EXEC shows PCSrc=1/PCWrite=1, then 0/0. Each takes 3 cycles; inst_count +2.
- opcode 111111 -> illegal=1 after DECODE, return to FETCH, inst_count unchanged, no RegWrite or PCWrite in EXEC.
- mem_ready held 0 in MEM for sw -> after 15 wait cycles: timeout=1, state IDLE, busy=0, mem_req=0.
- Reset pulse during WB of addi -> all outputs 0 in the same cycle, inst_count=0. Separately, with CNT_W=2, retire 5 instructions -> inst_count wraps to 1.

Source files
------------

// File: rtl/bubble_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_ctrl_pkg
//  Description : Shared opcodes, state encodings, ALUOp codes and opcode
//                classes for the BUBBLE multi-cycle control sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package bubble_ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Sequencer states
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle   = 3'd0;
    localparam state_t c_st_fetch  = 3'd1;
    localparam state_t c_st_decode = 3'd2;
    localparam state_t c_st_exec   = 3'd3;
    localparam state_t c_st_mem    = 3'd4;
    localparam state_t c_st_wb     = 3'd5;

    // ALU operation requests
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // Instruction classes latched in DECODE
    typedef logic [2:0] class_t;
    localparam class_t c_cls_nop  = 3'd0;
    localparam class_t c_cls_r    = 3'd1;
    localparam class_t c_cls_lw   = 3'd2;
    localparam class_t c_cls_sw   = 3'd3;
    localparam class_t c_cls_beq  = 3'd4;
    localparam class_t c_cls_addi = 3'd5;
    localparam class_t c_cls_ill  = 3'd6;

    // Map a primary opcode onto its instruction class
    function automatic class_t decode_class(input logic [5:0] op);
        class_t cls;
        case (op)
            OP_RTYPE: cls = c_cls_r;
            OP_LW:    cls = c_cls_lw;
            OP_SW:    cls = c_cls_sw;
            OP_BEQ:   cls = c_cls_beq;
            OP_ADDI:  cls = c_cls_addi;
            default:  cls = c_cls_ill;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_mem_wait_timer
//  Description : Counts cycles spent waiting on mem_ready and flags when the
//                wait has reached MAX_WAIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module bubble_mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,   // sequencer is in a memory-wait state
    input  logic i_ready,    // memory completes this cycle
    output logic o_expired   // counter has reached MAX_WAIT
);

    localparam int c_CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_expired;

    assign w_expired = (r_cnt == c_CNT_W'(MAX_WAIT));
    assign o_expired = w_expired;

    // Counter sits at zero outside FETCH/MEM so entering either starts fresh;
    // it saturates at MAX_WAIT while the sequencer bails out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_active || i_ready) begin
            r_cnt <= '0;
        end else if (!w_expired) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bubble_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_multicycle_ctrl
//  Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for
//                the BUBBLE datapath with memory handshake, wait timeout and
//                retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bubble_multicycle_ctrl
    import bubble_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             PCSrc,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] inst_count,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next_state;
    class_t           r_class;
    class_t           w_dec_class;
    logic             r_illegal;
    logic             r_timeout;
    logic [CNT_W-1:0] r_inst_count;
    logic             w_retire;
    logic             w_set_illegal;
    logic             w_set_timeout;
    logic             w_wait_active;
    logic             w_expired;
    logic             w_unused_funct;

    // funct is interpreted by the downstream ALU control when ALUOp=10
    assign w_unused_funct = ^funct;

    assign w_dec_class   = decode_class(opcode);
    assign w_wait_active = (r_state == c_st_fetch) || (r_state == c_st_mem);

    assign busy       = (r_state != c_st_idle);
    assign illegal    = r_illegal;
    assign timeout    = r_timeout;
    assign inst_count = r_inst_count;

    bubble_mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_active  (w_wait_active),
        .i_ready   (mem_ready),
        .o_expired (w_expired)
    );

    // State register; reset drops straight to IDLE so no late pulses escape
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction class captured once per instruction in DECODE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_class <= c_cls_nop;
        end else if (r_state == c_st_decode) begin
            r_class <= w_dec_class;
        end
    end

    // Sticky error flags and the wrapping retirement counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal    <= 1'b0;
            r_timeout    <= 1'b0;
            r_inst_count <= '0;
        end else begin
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_timeout <= 1'b1;
            if (w_retire)      r_inst_count <= r_inst_count + CNT_W'(1);
        end
    end

    // Next-state and Moore control decode (FETCH/EXEC add handshake/zero terms)
    always_comb begin
        w_next_state  = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        RegDst        = 1'b0;
        ALUSrc        = 1'b0;
        MemtoReg      = 1'b0;
        PCSrc         = 1'b0;
        PCWrite       = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ALUOp         = c_aluop_add;

        case (r_state)
            c_st_idle: begin
                if (run) w_next_state = c_st_fetch;
            end

            c_st_fetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_next_state = c_st_decode;
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_next_state  = c_st_idle;
                end
            end

            c_st_decode: begin
                if (w_dec_class == c_cls_ill) begin
                    w_set_illegal = 1'b1;
                    w_next_state  = run ? c_st_fetch : c_st_idle;
                end else begin
                    w_next_state = c_st_exec;
                end
            end

            c_st_exec: begin
                case (r_class)
                    c_cls_r: begin
                        ALUOp        = c_aluop_funct;
                        w_next_state = c_st_wb;
                    end
                    c_cls_lw, c_cls_sw: begin
                        ALUSrc       = 1'b1;
                        w_next_state = c_st_mem;
                    end
                    c_cls_addi: begin
                        ALUSrc       = 1'b1;
                        w_next_state = c_st_wb;
                    end
                    c_cls_beq: begin
                        ALUOp        = c_aluop_sub;
                        PCSrc        = zero;
                        PCWrite      = zero;
                        w_retire     = 1'b1;
                        w_next_state = run ? c_st_fetch : c_st_idle;
                    end
                    default: begin
                        w_next_state = c_st_idle;
                    end
                endcase
            end

            c_st_mem: begin
                mem_req = 1'b1;
                mem_we  = (r_class == c_cls_sw);
                if (mem_ready) begin
                    if (r_class == c_cls_sw) begin
                        w_retire     = 1'b1;
                        w_next_state = run ? c_st_fetch : c_st_idle;
                    end else begin
                        w_next_state = c_st_wb;
                    end
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_next_state  = c_st_idle;
                end
            end

            c_st_wb: begin
                RegWrite     = 1'b1;
                RegDst       = (r_class == c_cls_r);
                MemtoReg     = (r_class == c_cls_lw);
                w_retire     = 1'b1;
                w_next_state = run ? c_st_fetch : c_st_idle;
            end

            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bubble_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bubble_multicycle_ctrl
//  Description : Self-checking bench for bubble_multicycle_ctrl: cycle-by-cycle
//                vector table plus directed timeout, reset and wrap sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bubble_multicycle_ctrl;
    import bubble_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        RegDst, ALUSrc, MemtoReg, PCSrc, PCWrite, IRWrite, RegWrite;
    logic        mem_req, mem_we, illegal, timeout, busy;
    logic [1:0]  ALUOp;
    logic [15:0] inst_count;
    logic        RegDst2, ALUSrc2, MemtoReg2, PCSrc2, PCWrite2, IRWrite2, RegWrite2;
    logic        mem_req2, mem_we2, illegal2, timeout2, busy2;
    logic [1:0]  ALUOp2;
    logic [1:0]  inst_count2;

    int n_pass  = 0;
    int n_total = 0;

    bubble_multicycle_ctrl #(.CNT_W(16), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .RegDst(RegDst), .ALUSrc(ALUSrc),
        .MemtoReg(MemtoReg), .PCSrc(PCSrc), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .mem_req(mem_req), .mem_we(mem_we), .ALUOp(ALUOp),
        .illegal(illegal), .timeout(timeout), .inst_count(inst_count), .busy(busy)
    );

    bubble_multicycle_ctrl #(.CNT_W(2), .MAX_WAIT(15)) dut2 (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .RegDst(RegDst2), .ALUSrc(ALUSrc2),
        .MemtoReg(MemtoReg2), .PCSrc(PCSrc2), .PCWrite(PCWrite2), .IRWrite(IRWrite2),
        .RegWrite(RegWrite2), .mem_req(mem_req2), .mem_we(mem_we2), .ALUOp(ALUOp2),
        .illegal(illegal2), .timeout(timeout2), .inst_count(inst_count2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word: {busy, mem_req, mem_we, IRWrite, PCWrite, PCSrc,
    //                         ALUSrc, ALUOp[1:0], RegDst, MemtoReg, RegWrite,
    //                         illegal, timeout}
    localparam logic [13:0] E_IDLE    = 14'b0_0_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [13:0] E_FETCH_W = 14'b1_1_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [13:0] E_FETCH_R = 14'b1_1_0_1_1_0_0_00_0_0_0_0_0;
    localparam logic [13:0] E_DECODE  = 14'b1_0_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [13:0] E_EX_R    = 14'b1_0_0_0_0_0_0_10_0_0_0_0_0;
    localparam logic [13:0] E_EX_I    = 14'b1_0_0_0_0_0_1_00_0_0_0_0_0;
    localparam logic [13:0] E_EX_BT   = 14'b1_0_0_0_1_1_0_01_0_0_0_0_0;
    localparam logic [13:0] E_EX_BN   = 14'b1_0_0_0_0_0_0_01_0_0_0_0_0;
    localparam logic [13:0] E_MEM_L   = 14'b1_1_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [13:0] E_MEM_S   = 14'b1_1_1_0_0_0_0_00_0_0_0_0_0;
    localparam logic [13:0] E_WB_R    = 14'b1_0_0_0_0_0_0_00_1_0_1_0_0;
    localparam logic [13:0] E_WB_L    = 14'b1_0_0_0_0_0_0_00_0_1_1_0_0;
    localparam logic [13:0] E_WB_I    = 14'b1_0_0_0_0_0_0_00_0_0_1_0_0;
    localparam logic [13:0] F_ILL     = 14'b0_0_0_0_0_0_0_00_0_0_0_1_0;
    localparam logic [13:0] F_TO      = 14'b0_0_0_0_0_0_0_00_0_0_0_0_1;
    localparam logic [5:0]  OP_BAD    = 6'b111111;

    typedef struct {
        logic        run;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [13:0] ctrl;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [31];

    function automatic logic [13:0] actual_ctrl();
        return {busy, mem_req, mem_we, IRWrite, PCWrite, PCSrc, ALUSrc, ALUOp,
                RegDst, MemtoReg, RegWrite, illegal, timeout};
    endfunction

    task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic rd);
        run       = r;
        opcode    = op;
        zero      = z;
        mem_ready = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string nm, input logic [13:0] exp);
        logic [13:0] act;
        act = actual_ctrl();
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s ctrl: got %b expected %b", nm, act, exp);
    endtask

    task automatic check_cnt(input string nm, input logic [15:0] exp);
        n_total++;
        if (inst_count === exp) n_pass++;
        else $display("FAIL %s inst_count: got %0d expected %0d", nm, inst_count, exp);
    endtask

    initial begin
        // add, lw with stalls, beq taken/not taken, illegal, sw with run=0
        vecs[0]  = '{1'b0, OP_RTYPE, 1'b0, 1'b0, E_IDLE,            16'd0};
        vecs[1]  = '{1'b1, OP_RTYPE, 1'b0, 1'b0, E_IDLE,            16'd0};
        vecs[2]  = '{1'b1, OP_RTYPE, 1'b0, 1'b1, E_FETCH_R,         16'd0};
        vecs[3]  = '{1'b1, OP_RTYPE, 1'b0, 1'b0, E_DECODE,          16'd0};
        vecs[4]  = '{1'b1, OP_RTYPE, 1'b0, 1'b0, E_EX_R,            16'd0};
        vecs[5]  = '{1'b1, OP_RTYPE, 1'b0, 1'b0, E_WB_R,            16'd0};
        vecs[6]  = '{1'b1, OP_LW,    1'b0, 1'b0, E_FETCH_W,         16'd1};
        vecs[7]  = '{1'b1, OP_LW,    1'b0, 1'b0, E_FETCH_W,         16'd1};
        vecs[8]  = '{1'b1, OP_LW,    1'b0, 1'b0, E_FETCH_W,         16'd1};
        vecs[9]  = '{1'b1, OP_LW,    1'b0, 1'b1, E_FETCH_R,         16'd1};
        vecs[10] = '{1'b1, OP_LW,    1'b0, 1'b0, E_DECODE,          16'd1};
        vecs[11] = '{1'b1, OP_LW,    1'b0, 1'b0, E_EX_I,            16'd1};
        vecs[12] = '{1'b1, OP_LW,    1'b0, 1'b0, E_MEM_L,           16'd1};
        vecs[13] = '{1'b1, OP_LW,    1'b0, 1'b0, E_MEM_L,           16'd1};
        vecs[14] = '{1'b1, OP_LW,    1'b0, 1'b0, E_MEM_L,           16'd1};
        vecs[15] = '{1'b1, OP_LW,    1'b0, 1'b1, E_MEM_L,           16'd1};
        vecs[16] = '{1'b1, OP_LW,    1'b0, 1'b0, E_WB_L,            16'd1};
        vecs[17] = '{1'b1, OP_BEQ,   1'b1, 1'b1, E_FETCH_R,         16'd2};
        vecs[18] = '{1'b1, OP_BEQ,   1'b1, 1'b0, E_DECODE,          16'd2};
        vecs[19] = '{1'b1, OP_BEQ,   1'b1, 1'b0, E_EX_BT,           16'd2};
        vecs[20] = '{1'b1, OP_BEQ,   1'b0, 1'b1, E_FETCH_R,         16'd3};
        vecs[21] = '{1'b1, OP_BEQ,   1'b0, 1'b0, E_DECODE,          16'd3};
        vecs[22] = '{1'b1, OP_BEQ,   1'b0, 1'b0, E_EX_BN,           16'd3};
        vecs[23] = '{1'b1, OP_BAD,   1'b0, 1'b1, E_FETCH_R,         16'd4};
        vecs[24] = '{1'b1, OP_BAD,   1'b0, 1'b0, E_DECODE,          16'd4};
        vecs[25] = '{1'b1, OP_SW,    1'b0, 1'b1, E_FETCH_R | F_ILL, 16'd4};
        vecs[26] = '{1'b0, OP_SW,    1'b0, 1'b0, E_DECODE  | F_ILL, 16'd4};
        vecs[27] = '{1'b0, OP_SW,    1'b0, 1'b0, E_EX_I    | F_ILL, 16'd4};
        vecs[28] = '{1'b0, OP_SW,    1'b0, 1'b1, E_MEM_S   | F_ILL, 16'd4};
        vecs[29] = '{1'b0, OP_SW,    1'b0, 1'b1, E_IDLE    | F_ILL, 16'd5};
        vecs[30] = '{1'b0, OP_SW,    1'b0, 1'b1, E_IDLE    | F_ILL, 16'd5};

        reset = 1'b1;
        funct = 6'b100000;
        drive(1'b0, OP_RTYPE, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Table: inputs at posedge+1, compare at posedge+2
        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].run, vecs[i].op, vecs[i].zero, vecs[i].rdy);
            check_ctrl($sformatf("vec%0d", i), vecs[i].ctrl);
            check_cnt($sformatf("vec%0d", i), vecs[i].cnt);
            tick();
        end

        // sw whose MEM phase never sees mem_ready
        drive(1'b1, OP_SW, 1'b0, 1'b0); tick();               // IDLE
        drive(1'b1, OP_SW, 1'b0, 1'b1); tick();               // FETCH
        drive(1'b0, OP_SW, 1'b0, 1'b0); tick();               // DECODE
        drive(1'b0, OP_SW, 1'b0, 1'b0); tick();               // EXEC
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, OP_SW, 1'b0, 1'b0);
            if (k == 0)  check_ctrl("to_mem_first", E_MEM_S | F_ILL);
            if (k == 15) check_ctrl("to_mem_last",  E_MEM_S | F_ILL);
            tick();
        end
        drive(1'b0, OP_SW, 1'b0, 1'b0);
        check_ctrl("to_idle", E_IDLE | F_ILL | F_TO);
        check_cnt("to_idle", 16'd5);
        tick();
        drive(1'b0, OP_SW, 1'b0, 1'b1);
        check_ctrl("to_sticky", E_IDLE | F_ILL | F_TO);

        // addi interrupted by reset while in WB
        drive(1'b1, OP_ADDI, 1'b0, 1'b0); tick();             // IDLE
        drive(1'b1, OP_ADDI, 1'b0, 1'b1); tick();             // FETCH
        drive(1'b1, OP_ADDI, 1'b0, 1'b0); tick();             // DECODE
        drive(1'b1, OP_ADDI, 1'b0, 1'b0);
        check_ctrl("addi_exec", E_EX_I | F_ILL | F_TO);
        tick();
        drive(1'b1, OP_ADDI, 1'b0, 1'b0);
        check_ctrl("addi_wb", E_WB_I | F_ILL | F_TO);
        #1 reset = 1'b1;
        #1;
        check_ctrl("rst_mid_wb", E_IDLE);
        check_cnt("rst_mid_wb", 16'd0);
        #2 reset = 1'b0;
        drive(1'b0, OP_ADDI, 1'b0, 1'b0);
        tick();
        check_ctrl("rst_after", E_IDLE);

        // Five back-to-back addi: 16-bit counter reads 5, 2-bit one wraps to 1
        drive(1'b1, OP_ADDI, 1'b0, 1'b1);
        repeat (20) tick();
        drive(1'b0, OP_ADDI, 1'b0, 1'b1);
        check_ctrl("wrap_last_wb", E_WB_I);
        tick();
        drive(1'b0, OP_ADDI, 1'b0, 1'b1);
        check_ctrl("wrap_idle", E_IDLE);
        check_cnt("wrap_cnt16", 16'd5);
        n_total++;
        if (inst_count2 === 2'd1) n_pass++;
        else $display("FAIL wrap_cnt2 inst_count: got %0d expected 1", inst_count2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
